// File: rtl/rx_sg_req_gen.sv
// Scatter-gather read request generator: walks SG elements for one receive
// transaction and emits PCIe-sized read requests that never cross a 4 KB page.
module rx_sg_req_gen #(
  parameter int unsigned C_MAX_READ_REQ = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  CONFIG_MAX_READ_REQUEST_SIZE,
  input  logic        TXN_START,
  input  logic [31:0] TXN_LEN,
  input  logic        TXN_ABORT,
  input  logic [63:0] SG_ELEM_ADDR,
  input  logic [31:0] SG_ELEM_LEN,
  input  logic        SG_ELEM_RDY,
  output logic        SG_ELEM_REN,
  input  logic        SPACE_OK,
  output logic        RX_REQ,
  input  logic        RX_REQ_ACK,
  output logic [1:0]  RX_REQ_TAG,
  output logic [63:0] RX_REQ_ADDR,
  output logic [9:0]  RX_REQ_LEN,
  output logic        REQ_DONE,
  output logic [31:0] WORDS_REQD
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CALC,
    S_REQ,
    S_DONE
  } state_e;

  localparam logic [2:0] MAX_SZ_CAP = (C_MAX_READ_REQ > 5) ? 3'd5 : 3'(C_MAX_READ_REQ);

  state_e      state_q,      state_d;
  logic [63:0] cur_addr_q,   cur_addr_d;
  logic [31:0] elem_rem_q,   elem_rem_d;
  logic [31:0] txn_rem_q,    txn_rem_d;
  logic [31:0] words_q,      words_d;
  logic [10:0] req_len_q,    req_len_d;
  logic [1:0]  tag_q,        tag_d;
  logic        rx_req_q,     rx_req_d;
  logic        done_q,       done_d;
  logic        abort_pend_q, abort_pend_d;
  logic        elem_ren;

  logic [2:0]  cfg_sz;
  logic [2:0]  max_sz;
  logic [10:0] wmax;
  logic [10:0] bound_words;
  logic [10:0] calc_len;
  logic [31:0] elem_rem_ack;
  logic [31:0] txn_rem_ack;

  // Effective max request size in words, clamped by both config and parameter cap
  always_comb begin
    cfg_sz = (CONFIG_MAX_READ_REQUEST_SIZE > 3'd5) ? 3'd5 : CONFIG_MAX_READ_REQUEST_SIZE;
    max_sz = (cfg_sz < MAX_SZ_CAP) ? cfg_sz : MAX_SZ_CAP;
    wmax   = 11'd32 << max_sz;
  end

  // Request length: smallest of max size, words left to the 4 KB page end,
  // element remainder and transaction remainder (result is 1..1024)
  always_comb begin
    bound_words = 11'd1024 - {1'b0, cur_addr_q[11:2]};
    calc_len    = (wmax < bound_words) ? wmax : bound_words;
    if (elem_rem_q < {21'd0, calc_len}) calc_len = elem_rem_q[10:0];
    if (txn_rem_q < {21'd0, calc_len}) calc_len = txn_rem_q[10:0];
  end

  // Remainders after the outstanding request is acknowledged
  always_comb begin
    elem_rem_ack = elem_rem_q - {21'd0, req_len_q};
    txn_rem_ack  = txn_rem_q - {21'd0, req_len_q};
  end

  // Next-state and datapath updates for the transaction walker
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    elem_rem_d   = elem_rem_q;
    txn_rem_d    = txn_rem_q;
    words_d      = words_q;
    req_len_d    = req_len_q;
    tag_d        = tag_q;
    rx_req_d     = rx_req_q;
    abort_pend_d = abort_pend_q;
    elem_ren     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (TXN_START) begin
          txn_rem_d  = TXN_LEN;
          elem_rem_d = '0;
          words_d    = '0;
          state_d    = (TXN_ABORT || TXN_LEN == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (TXN_ABORT) begin
          state_d = S_DONE;
        end else if (SG_ELEM_RDY) begin
          elem_ren   = 1'b1;
          cur_addr_d = SG_ELEM_ADDR & ~64'h3;
          elem_rem_d = SG_ELEM_LEN;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        if (TXN_ABORT) begin
          state_d = S_DONE;
        end else if (elem_rem_q == '0) begin
          // Zero-length element: already consumed, nothing to request
          state_d = S_FETCH;
        end else begin
          req_len_d = calc_len;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (rx_req_q) begin
          // An abort seen mid-handshake is remembered and honoured after the ack
          if (TXN_ABORT) abort_pend_d = 1'b1;
          if (RX_REQ_ACK) begin
            rx_req_d   = 1'b0;
            cur_addr_d = cur_addr_q + {51'd0, req_len_q, 2'b00};
            elem_rem_d = elem_rem_ack;
            txn_rem_d  = txn_rem_ack;
            words_d    = words_q + {21'd0, req_len_q};
            tag_d      = tag_q + 2'd1;
            if (txn_rem_ack == '0 || abort_pend_q || TXN_ABORT) begin
              state_d = S_DONE;
            end else if (elem_rem_ack == '0) begin
              state_d = S_FETCH;
            end else begin
              state_d = S_CALC;
            end
          end
        end else if (TXN_ABORT) begin
          state_d = S_DONE;
        end else if (SPACE_OK) begin
          rx_req_d = 1'b1;
        end
      end
      S_DONE: begin
        abort_pend_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      elem_rem_q   <= '0;
      txn_rem_q    <= '0;
      words_q      <= '0;
      req_len_q    <= '0;
      tag_q        <= '0;
      rx_req_q     <= 1'b0;
      done_q       <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      elem_rem_q   <= elem_rem_d;
      txn_rem_q    <= txn_rem_d;
      words_q      <= words_d;
      req_len_q    <= req_len_d;
      tag_q        <= tag_d;
      rx_req_q     <= rx_req_d;
      done_q       <= done_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  // Consume strobe is qualified combinationally by SG_ELEM_RDY so it can never
  // fire against an empty upstream; everything else comes straight from flops.
  assign SG_ELEM_REN = elem_ren;
  assign RX_REQ      = rx_req_q;
  assign RX_REQ_TAG  = tag_q;
  assign RX_REQ_ADDR = cur_addr_q;
  assign RX_REQ_LEN  = req_len_q[9:0];
  assign REQ_DONE    = done_q;
  assign WORDS_REQD  = words_q;

endmodule

// File: tb/tb_rx_sg_req_gen.sv
// Self-checking bench for rx_sg_req_gen: table-driven single-element
// transactions plus hand-written multi-element, backpressure, abort and reset cases.
module tb_rx_sg_req_gen;

  localparam logic [2:0] CMAX = 3'd5;

  logic        clk;
  logic        RST;
  logic [2:0]  CONFIG_MAX_READ_REQUEST_SIZE;
  logic        TXN_START;
  logic [31:0] TXN_LEN;
  logic        TXN_ABORT;
  logic [63:0] SG_ELEM_ADDR;
  logic [31:0] SG_ELEM_LEN;
  logic        SG_ELEM_RDY;
  logic        SG_ELEM_REN;
  logic        SPACE_OK;
  logic        RX_REQ;
  logic        RX_REQ_ACK;
  logic [1:0]  RX_REQ_TAG;
  logic [63:0] RX_REQ_ADDR;
  logic [9:0]  RX_REQ_LEN;
  logic        REQ_DONE;
  logic [31:0] WORDS_REQD;

  rx_sg_req_gen #(.C_MAX_READ_REQ(5)) dut (
    .CLK                          (clk),
    .RST                          (RST),
    .CONFIG_MAX_READ_REQUEST_SIZE (CONFIG_MAX_READ_REQUEST_SIZE),
    .TXN_START                    (TXN_START),
    .TXN_LEN                      (TXN_LEN),
    .TXN_ABORT                    (TXN_ABORT),
    .SG_ELEM_ADDR                 (SG_ELEM_ADDR),
    .SG_ELEM_LEN                  (SG_ELEM_LEN),
    .SG_ELEM_RDY                  (SG_ELEM_RDY),
    .SG_ELEM_REN                  (SG_ELEM_REN),
    .SPACE_OK                     (SPACE_OK),
    .RX_REQ                       (RX_REQ),
    .RX_REQ_ACK                   (RX_REQ_ACK),
    .RX_REQ_TAG                   (RX_REQ_TAG),
    .RX_REQ_ADDR                  (RX_REQ_ADDR),
    .RX_REQ_LEN                   (RX_REQ_LEN),
    .REQ_DONE                     (REQ_DONE),
    .WORDS_REQD                   (WORDS_REQD)
  );

  typedef struct {
    logic [63:0] addr;
    logic [9:0]  len;
    logic [1:0]  tag;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] len;
  } elem_t;

  typedef struct {
    logic [2:0]  cfg;
    logic [63:0] addr;
    logic [31:0] elen;
    logic [31:0] tlen;
    int          nreq;
    logic [31:0] words;
  } vec_t;

  exp_t  exp_q[$];
  elem_t elems[$];
  vec_t  vecs[6];

  int n_chk = 0;
  int n_fail = 0;
  int ren_cnt = 0;
  int req_cnt = 0;
  int done_cnt = 0;
  int hold_cnt = 0;
  int ack_delay = 0;
  bit req_seen = 0;
  bit ack_next = 0;
  bit spurious_ack = 0;
  bit elem_en = 1;
  logic [1:0]  tb_tag = '0;
  logic [63:0] hold_addr;
  logic [9:0]  hold_len;
  logic [1:0]  hold_tag;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_elems();
    SG_ELEM_RDY = elem_en && (elems.size() != 0);
    if (elems.size() != 0) begin
      SG_ELEM_ADDR = elems[0].addr;
      SG_ELEM_LEN  = elems[0].len;
    end else begin
      SG_ELEM_ADDR = '0;
      SG_ELEM_LEN  = '0;
    end
  endtask

  // One clock: sample/score at negedge, then update stimulus just after posedge
  task automatic cycle();
    bit   consume;
    exp_t e;
    @(negedge clk);
    consume = 0;
    if (SG_ELEM_REN) begin
      ren_cnt++;
      consume = 1;
      check("ren_needs_rdy", {63'd0, SG_ELEM_RDY}, 64'd1);
    end
    if (RX_REQ) begin
      if (!req_seen) begin
        req_seen = 1;
        req_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_req", {63'd0, RX_REQ}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("req_addr", RX_REQ_ADDR, e.addr);
          check("req_len", {54'd0, RX_REQ_LEN}, {54'd0, e.len});
          check("req_tag", {62'd0, RX_REQ_TAG}, {62'd0, e.tag});
        end
        hold_addr = RX_REQ_ADDR;
        hold_len  = RX_REQ_LEN;
        hold_tag  = RX_REQ_TAG;
      end else begin
        check("hold_addr", RX_REQ_ADDR, hold_addr);
        check("hold_len", {54'd0, RX_REQ_LEN}, {54'd0, hold_len});
        check("hold_tag", {62'd0, RX_REQ_TAG}, {62'd0, hold_tag});
      end
      if (RX_REQ_ACK) begin
        req_seen = 0;
        hold_cnt = 0;
        ack_next = 0;
      end else begin
        hold_cnt++;
        ack_next = (hold_cnt > ack_delay);
      end
    end else begin
      req_seen = 0;
      hold_cnt = 0;
      ack_next = spurious_ack;
    end
    if (REQ_DONE) done_cnt++;
    @(posedge clk);
    #1;
    RX_REQ_ACK = ack_next;
    if (consume && elems.size() != 0) void'(elems.pop_front());
    drive_elems();
  endtask

  // Reference walk of the loaded elements; pushes expected requests
  task automatic model_txn(input logic [2:0] cfg, input logic [31:0] tlen, output int n_ren);
    logic [2:0]  sz;
    logic [31:0] wmax, rem, e, l, b;
    logic [63:0] a;
    sz = (cfg > 3'd5) ? 3'd5 : cfg;
    if (sz > CMAX) sz = CMAX;
    wmax  = 32'd32 << sz;
    rem   = tlen;
    n_ren = 0;
    foreach (elems[i]) begin
      if (rem == 0) break;
      n_ren++;
      a = elems[i].addr;
      a[1:0] = 2'b00;
      e = elems[i].len;
      while (e != 0 && rem != 0) begin
        b = 32'd1024 - {22'd0, a[11:2]};
        l = wmax;
        if (e < l) l = e;
        if (rem < l) l = rem;
        if (b < l) l = b;
        exp_q.push_back('{a, l[9:0], tb_tag});
        tb_tag = tb_tag + 2'd1;
        a = a + {30'd0, l, 2'b00};
        e = e - l;
        rem = rem - l;
      end
    end
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    for (int c = 0; c < budget && done_cnt == d0; c++) cycle();
    check({name, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic run_txn(input logic [2:0] cfg, input logic [31:0] tlen, input int exp_nreq,
                         input logic [31:0] exp_words, input string name);
    int d0, r0, q0, n_ren;
    model_txn(cfg, tlen, n_ren);
    drive_elems();
    CONFIG_MAX_READ_REQUEST_SIZE = cfg;
    d0 = done_cnt;
    r0 = ren_cnt;
    q0 = req_cnt;
    TXN_LEN   = tlen;
    TXN_START = 1'b1;
    cycle();
    TXN_START = 1'b0;
    wait_done(d0, 4000, name);
    cycle();
    cycle();
    check({name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_nreq"}, 64'(req_cnt - q0), 64'(exp_nreq));
    check({name, "_nren"}, 64'(ren_cnt - r0), 64'(n_ren));
    check({name, "_words"}, {32'd0, WORDS_REQD}, {32'd0, exp_words});
    check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    elems.delete();
    drive_elems();
  endtask

  initial begin
    int d0, r0, q0, n_ren;

    vecs[0] = '{3'd2, 64'h0000_0000_0000_1000, 32'd300,  32'd300,  3, 32'd300};
    vecs[1] = '{3'd5, 64'h0000_0000_0000_0FF0, 32'd1024, 32'd1024, 2, 32'd1024};
    vecs[2] = '{3'd0, 64'h0000_0000_0000_0000, 32'd100,  32'd100,  4, 32'd100};
    vecs[3] = '{3'd7, 64'h0000_0000_0000_0000, 32'd1024, 32'd1024, 1, 32'd1024};
    vecs[4] = '{3'd3, 64'h0000_0000_0000_1F02, 32'd200,  32'd150,  2, 32'd150};
    vecs[5] = '{3'd1, 64'h0000_0000_FFFF_FF00, 32'd100,  32'd100,  2, 32'd100};

    RST = 1'b1;
    CONFIG_MAX_READ_REQUEST_SIZE = 3'd2;
    TXN_START = 1'b0;
    TXN_LEN = '0;
    TXN_ABORT = 1'b0;
    SPACE_OK = 1'b1;
    RX_REQ_ACK = 1'b0;
    drive_elems();

    #3;
    check("rst_rx_req", {63'd0, RX_REQ}, 64'd0);
    check("rst_ren", {63'd0, SG_ELEM_REN}, 64'd0);
    check("rst_done", {63'd0, REQ_DONE}, 64'd0);
    check("rst_tag", {62'd0, RX_REQ_TAG}, 64'd0);
    check("rst_addr", RX_REQ_ADDR, 64'd0);
    check("rst_len", {54'd0, RX_REQ_LEN}, 64'd0);
    check("rst_words", {32'd0, WORDS_REQD}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b0;
    cycle();

    // Single-element transactions from the table
    for (int i = 0; i < 6; i++) begin
      elems.push_back('{vecs[i].addr, vecs[i].elen});
      run_txn(vecs[i].cfg, vecs[i].tlen, vecs[i].nreq, vecs[i].words, $sformatf("vec%0d", i));
    end

    // Zero-length transaction: straight to done, nothing consumed
    elems.push_back('{64'h100, 32'd4});
    run_txn(3'd2, 32'd0, 0, 32'd0, "txn_len0");

    // Multiple elements with a zero-length one and truncation by TXN_LEN
    elems.push_back('{64'h2000, 32'd10});
    elems.push_back('{64'h0, 32'd0});
    elems.push_back('{64'h8000, 32'd50});
    run_txn(3'd2, 32'd40, 2, 32'd40, "multi_elem");

    // Backpressure: no request while SPACE_OK is low, stray ACKs ignored
    CONFIG_MAX_READ_REQUEST_SIZE = 3'd2;
    elems.push_back('{64'h5000, 32'd16});
    model_txn(3'd2, 32'd16, n_ren);
    drive_elems();
    d0 = done_cnt;
    SPACE_OK = 1'b0;
    spurious_ack = 1;
    TXN_LEN = 32'd16;
    TXN_START = 1'b1;
    cycle();
    TXN_START = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      check("bp_no_req", {63'd0, RX_REQ}, 64'd0);
    end
    spurious_ack = 0;
    cycle();
    SPACE_OK = 1'b1;
    ack_delay = 5;
    for (int c = 0; c < 10 && !req_seen; c++) cycle();
    check("bp_req_seen", {63'd0, RX_REQ}, 64'd1);
    for (int c = 0; c < 10; c++) begin
      SPACE_OK = ~SPACE_OK;
      cycle();
    end
    SPACE_OK = 1'b1;
    ack_delay = 0;
    wait_done(d0, 50, "bp");
    check("bp_words", {32'd0, WORDS_REQD}, 64'd16);
    check("bp_sb_empty", 64'(exp_q.size()), 64'd0);
    elems.delete();
    drive_elems();

    // Abort while waiting for an element
    elem_en = 0;
    elems.push_back('{64'h9000, 32'd8});
    drive_elems();
    d0 = done_cnt;
    r0 = ren_cnt;
    q0 = req_cnt;
    TXN_LEN = 32'd8;
    TXN_START = 1'b1;
    cycle();
    TXN_START = 1'b0;
    cycle();
    cycle();
    TXN_ABORT = 1'b1;
    cycle();
    cycle();
    TXN_ABORT = 1'b0;
    check("abort_fetch_done", 64'(done_cnt - d0), 64'd1);
    cycle();
    check("abort_fetch_nreq", 64'(req_cnt - q0), 64'd0);
    check("abort_fetch_nren", 64'(ren_cnt - r0), 64'd0);
    elem_en = 1;
    elems.delete();
    drive_elems();

    // Start and abort together: abort wins, element untouched
    elems.push_back('{64'hA000, 32'd8});
    drive_elems();
    d0 = done_cnt;
    r0 = ren_cnt;
    q0 = req_cnt;
    TXN_LEN = 32'd8;
    TXN_START = 1'b1;
    TXN_ABORT = 1'b1;
    cycle();
    TXN_START = 1'b0;
    TXN_ABORT = 1'b0;
    wait_done(d0, 3, "start_abort");
    cycle();
    check("start_abort_nreq", 64'(req_cnt - q0), 64'd0);
    check("start_abort_nren", 64'(ren_cnt - r0), 64'd0);
    elems.delete();
    drive_elems();

    // Abort while RX_REQ is held: handshake completes, then done
    CONFIG_MAX_READ_REQUEST_SIZE = 3'd2;
    elems.push_back('{64'h3000, 32'd500});
    drive_elems();
    exp_q.push_back('{64'h3000, 10'd128, tb_tag});
    tb_tag = tb_tag + 2'd1;
    ack_delay = 1000;
    d0 = done_cnt;
    q0 = req_cnt;
    TXN_LEN = 32'd500;
    TXN_START = 1'b1;
    cycle();
    TXN_START = 1'b0;
    for (int c = 0; c < 20 && !req_seen; c++) cycle();
    check("abort_req_seen", {63'd0, RX_REQ}, 64'd1);
    TXN_ABORT = 1'b1;
    repeat (3) cycle();
    check("abort_req_held", {63'd0, RX_REQ}, 64'd1);
    check("abort_req_no_early_done", 64'(done_cnt - d0), 64'd0);
    ack_delay = 0;
    wait_done(d0, 20, "abort_req");
    TXN_ABORT = 1'b0;
    cycle();
    cycle();
    check("abort_req_nreq", 64'(req_cnt - q0), 64'd1);
    check("abort_req_words", {32'd0, WORDS_REQD}, 64'd128);
    check("abort_req_sb_empty", 64'(exp_q.size()), 64'd0);
    elems.delete();
    drive_elems();

    // Asynchronous reset with a request outstanding and an ACK arriving with it
    elems.push_back('{64'h6000, 32'd64});
    drive_elems();
    exp_q.push_back('{64'h6000, 10'd64, tb_tag});
    ack_delay = 1000;
    TXN_LEN = 32'd64;
    TXN_START = 1'b1;
    cycle();
    TXN_START = 1'b0;
    for (int c = 0; c < 20 && !req_seen; c++) cycle();
    check("rst_mid_req_seen", {63'd0, RX_REQ}, 64'd1);
    #2;
    RX_REQ_ACK = 1'b1;
    RST = 1'b1;
    #1;
    check("rst_mid_rx_req", {63'd0, RX_REQ}, 64'd0);
    check("rst_mid_tag", {62'd0, RX_REQ_TAG}, 64'd0);
    check("rst_mid_addr", RX_REQ_ADDR, 64'd0);
    check("rst_mid_len", {54'd0, RX_REQ_LEN}, 64'd0);
    check("rst_mid_done", {63'd0, REQ_DONE}, 64'd0);
    check("rst_mid_ren", {63'd0, SG_ELEM_REN}, 64'd0);
    RX_REQ_ACK = 1'b0;
    ack_next = 0;
    req_seen = 0;
    hold_cnt = 0;
    ack_delay = 0;
    tb_tag = '0;
    exp_q.delete();
    elems.delete();
    drive_elems();
    @(posedge clk);
    #1;
    RST = 1'b0;
    cycle();
    elems.push_back('{64'h7000, 32'd8});
    run_txn(3'd2, 32'd8, 1, 32'd8, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
